// File: rtl/ccff_bank_shadowed.sv
// Configuration-chain bank with shadow registers: bitstreams shift through the
// chains while the fabric keeps seeing the last committed (shadow) configuration.
module ccff_bank_shadowed #(
  parameter int NUM_CHAINS = 2,
  parameter int CHAIN_LEN  = 16,
  parameter int CNT_W      = 8
) (
  input  logic                             prog_clk,
  input  logic                             prog_reset,
  input  logic [NUM_CHAINS-1:0]            ccff_head,
  input  logic                             shift_en,
  input  logic                             capture,
  input  logic                             commit,
  input  logic                             isol_n,
  output logic [NUM_CHAINS-1:0]            ccff_tail,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0]  cfg_out,
  output logic [CNT_W-1:0]                 shift_cnt,
  output logic                             frame_done,
  output logic                             commit_err,
  output logic                             busy
);

  typedef enum logic [1:0] {IDLE, SHIFTING, FULL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(CHAIN_LEN);

  state_t               state;
  state_t               next_state;
  logic [CHAIN_LEN-1:0] sr     [NUM_CHAINS];
  logic [CHAIN_LEN-1:0] shadow [NUM_CHAINS];
  logic [CNT_W-1:0]     next_cnt;
  logic                 commit_ok;
  logic                 do_capture;

  assign frame_done = (shift_cnt >= LEN_C);
  assign commit_ok  = commit & frame_done;
  // A commit in the same cycle wins over capture
  assign do_capture = capture & ~commit;
  assign busy       = (state == SHIFTING);

  always_comb begin
    next_cnt = shift_cnt;
    if (do_capture)
      next_cnt = '0;
    else if (shift_en)
      next_cnt = commit_ok ? CNT_W'(1)
               : (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + 1'b1;
    else if (commit_ok)
      next_cnt = '0;
  end

  // The state tracks which range the shift count falls in
  always_comb begin
    next_state = FULL;
    if (next_cnt == '0)
      next_state = IDLE;
    else if (next_cnt < LEN_C)
      next_state = SHIFTING;
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state      <= IDLE;
      shift_cnt  <= '0;
      commit_err <= 1'b0;
      for (int c = 0; c < NUM_CHAINS; c++) begin
        sr[c]     <= '0;
        shadow[c] <= '0;
      end
    end else begin
      state      <= next_state;
      shift_cnt  <= next_cnt;
      commit_err <= commit & ~frame_done;
      for (int c = 0; c < NUM_CHAINS; c++) begin
        if (commit_ok)
          shadow[c] <= sr[c];
        if (do_capture)
          sr[c] <= shadow[c];
        else if (shift_en)
          sr[c] <= {sr[c][CHAIN_LEN-2:0], ccff_head[c]};
      end
    end
  end

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_out
    assign ccff_tail[c]                       = sr[c][CHAIN_LEN-1];
    assign cfg_out[c*CHAIN_LEN +: CHAIN_LEN] = isol_n ? shadow[c] : '0;
  end

endmodule

// File: tb/tb_ccff_bank_shadowed.sv
// Randomized and directed bench for ccff_bank_shadowed against a word-level
// model of chains, shadows and the shift counter.
module tb_ccff_bank_shadowed;

  localparam int NC = 2;
  localparam int L  = 8;
  localparam int CW = 8;

  logic            prog_clk;
  logic            prog_reset;
  logic [NC-1:0]   ccff_head;
  logic            shift_en;
  logic            capture;
  logic            commit;
  logic            isol_n;
  logic [NC-1:0]   ccff_tail;
  logic [NC*L-1:0] cfg_out;
  logic [CW-1:0]   shift_cnt;
  logic            frame_done;
  logic            commit_err;
  logic            busy;

  ccff_bank_shadowed #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .CNT_W(CW)) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff_head  (ccff_head),
    .shift_en   (shift_en),
    .capture    (capture),
    .commit     (commit),
    .isol_n     (isol_n),
    .ccff_tail  (ccff_tail),
    .cfg_out    (cfg_out),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done),
    .commit_err (commit_err),
    .busy       (busy)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: chain words with the oldest bit at the MSB
  logic [L-1:0] m_sr     [NC];
  logic [L-1:0] m_shadow [NC];
  int           m_cnt;
  bit           m_err;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    for (int c = 0; c < NC; c++) begin
      m_sr[c]     = '0;
      m_shadow[c] = '0;
    end
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic modelStep(input bit sh, input bit cap, input bit com, input logic [NC-1:0] head);
    bit           fd;
    bit           ok;
    logic [L-1:0] old;
    fd    = (m_cnt >= L);
    ok    = com && fd;
    m_err = com && !fd;
    for (int c = 0; c < NC; c++) begin
      old = m_sr[c];
      if (cap && !com) m_sr[c] = m_shadow[c];
      else if (sh)     m_sr[c] = L'((old << 1) | L'(head[c]));
      if (ok) m_shadow[c] = old;
    end
    if (cap && !com)   m_cnt = 0;
    else if (sh)       m_cnt = ok ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    else if (ok)       m_cnt = 0;
  endtask

  task automatic compareAll(input string tag);
    logic [NC-1:0]   exp_tail;
    logic [NC*L-1:0] exp_cfg;
    for (int c = 0; c < NC; c++) begin
      exp_tail[c]       = m_sr[c][L-1];
      exp_cfg[c*L +: L] = isol_n ? m_shadow[c] : '0;
    end
    checkOutput({tag, ".tail"}, ccff_tail, exp_tail);
    checkOutput({tag, ".cfg"},  cfg_out, exp_cfg);
    checkOutput({tag, ".cnt"},  shift_cnt, m_cnt);
    checkOutput({tag, ".done"}, frame_done, m_cnt >= L);
    checkOutput({tag, ".err"},  commit_err, m_err);
    checkOutput({tag, ".busy"}, busy, (m_cnt > 0) && (m_cnt < L));
  endtask

  // Drives one cycle, advances the model, then compares every output
  task automatic applyStimulus(input bit sh, input bit cap, input bit com, input logic [NC-1:0] head);
    shift_en  = sh;
    capture   = cap;
    commit    = com;
    ccff_head = head;
    @(posedge prog_clk);
    #1;
    modelStep(sh, cap, com, head);
    shift_en = 0;
    capture  = 0;
    commit   = 0;
    compareAll("step");
  endtask

  logic [7:0]    seq0;
  logic [7:0]    a5;
  logic [NC-1:0] hist [$];
  logic [NC-1:0] h;
  logic [L-1:0]  exp_ch [NC];
  bit            sh_r, cap_r, com_r;

  initial begin
    prog_reset = 1; shift_en = 0; capture = 0; commit = 0; isol_n = 1; ccff_head = '0;
    modelReset();
    repeat (2) @(posedge prog_clk);
    #1 prog_reset = 0;
    compareAll("reset");

    // Load 10110010 into chain 0 and all ones into chain 1, then commit
    seq0 = 8'b10110010;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, {1'b1, seq0[7-i]});
      checkOutput("frame_done_rise", frame_done, i == 7);
    end
    applyStimulus(0, 0, 1, '0);
    checkOutput("commit_ch0", cfg_out[7:0], 8'hB2);
    checkOutput("commit_ch1", cfg_out[15:8], 8'hFF);
    checkOutput("commit_cnt", shift_cnt, 0);
    checkOutput("commit_err_lo", commit_err, 0);

    // Premature commit is rejected
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, NC'($urandom));
    applyStimulus(0, 0, 1, '0);
    checkOutput("early_err", commit_err, 1);
    checkOutput("early_cfg", cfg_out, 16'hFFB2);
    checkOutput("early_cnt", shift_cnt, 5);
    checkOutput("early_busy", busy, 1);
    applyStimulus(0, 0, 0, '0);
    checkOutput("early_err_pulse", commit_err, 0);

    // Commit 0xA5 to chain 0, capture it back and read it out MSB first
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, {1'b0, a5[7-i]});
    applyStimulus(0, 0, 1, '0);
    checkOutput("a5_commit", cfg_out[7:0], 8'hA5);
    applyStimulus(0, 1, 0, '0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("readback_bit", ccff_tail[0], a5[7-i]);
      applyStimulus(1, 0, 0, '0);
    end
    checkOutput("readback_cfg", cfg_out[7:0], 8'hA5);

    // 20-bit pass-through, then commit with shift in the same cycle
    applyStimulus(0, 1, 0, '0);
    for (int i = 0; i < 20; i++) begin
      h = NC'($urandom);
      hist.push_back(h);
      applyStimulus(1, 0, 0, h);
      if (i >= 7) checkOutput("passthru_tail", ccff_tail, hist[i-7]);
    end
    checkOutput("passthru_cnt", shift_cnt, 20);
    checkOutput("passthru_done", frame_done, 1);
    checkOutput("passthru_err", commit_err, 0);
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < L; k++) exp_ch[c][L-1-k] = hist[12+k][c];
    applyStimulus(1, 0, 1, NC'($urandom));
    checkOutput("cs_ch0", cfg_out[7:0], exp_ch[0]);
    checkOutput("cs_ch1", cfg_out[15:8], exp_ch[1]);
    checkOutput("cs_cnt", shift_cnt, 1);
    checkOutput("cs_err", commit_err, 0);

    // Isolation gating on an all-ones shadow
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 2'b11);
    applyStimulus(0, 0, 1, '0);
    isol_n = 0;
    #1 checkOutput("isol_lo", cfg_out, 16'h0000);
    isol_n = 1;
    #1 checkOutput("isol_hi", cfg_out, 16'hFFFF);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) isol_n = ~isol_n;
      sh_r  = ($urandom_range(0, 9) < 7);
      cap_r = ($urandom_range(0, 19) == 0);
      com_r = ($urandom_range(0, 9) == 0);
      applyStimulus(sh_r, cap_r, com_r, NC'($urandom));
    end
    isol_n = 1;

    // Asynchronous reset in the middle of a shift
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 2'b11);
    shift_en = 1;
    #2 prog_reset = 1;
    #1;
    modelReset();
    checkOutput("rst_tail", ccff_tail, 0);
    checkOutput("rst_cfg", cfg_out, 0);
    checkOutput("rst_cnt", shift_cnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", frame_done, 0);
    shift_en = 0;
    @(posedge prog_clk);
    #1 prog_reset = 0;
    compareAll("post_reset");
    applyStimulus(1, 0, 0, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ccff_bank_shadowed.md
Name: ccff_bank_shadowed

Overview:
- Parametrised configuration-chain bank for bottom/IO tiles.
- Provides NUM_CHAINS independent ccff scan chains of CHAIN_LEN bits, all shifted on prog_clk.
- Adds shadow registers loaded by an explicit commit, so the fabric's config stays stable while a new bitstream streams through.
- Adds shadow readback (capture), a shift counter, frame-complete status, and isolation gating of config outputs.

Parameters:
- NUM_CHAINS, 2, number of parallel configuration chains (>=1).
- CHAIN_LEN, 16, bits per chain (>=2).
- CNT_W, 8, shift-counter width; must satisfy 2^CNT_W-1 >= CHAIN_LEN.

Ports:
- prog_clk  input  1  configuration clock; the block's only clock.
- prog_reset  input  1  asynchronous, active-high reset.
- ccff_head  input  NUM_CHAINS  serial input per chain.
- shift_en  input  1  shift all chains one bit this cycle.
- capture  input  1  load shadow into shift regs (readback).
- commit  input  1  copy shift regs into shadow.
- isol_n  input  1  0 forces cfg_out to all-zero.
- ccff_tail  output  NUM_CHAINS  serial output per chain = MSB of shift reg.
- cfg_out  output  NUM_CHAINS*CHAIN_LEN  shadow contents; chain c occupies [c*CHAIN_LEN +: CHAIN_LEN].
- shift_cnt  output  CNT_W  shifts since last capture/commit, saturating.
- frame_done  output  1  shift_cnt >= CHAIN_LEN.
- commit_err  output  1  one-cycle pulse when commit is rejected.
- busy  output  1  FSM in SHIFTING.

Behaviour:
- Reset (asynchronous, active-high):
  - All shift regs, shadows, shift_cnt, commit_err = 0; state IDLE.
  - Hence ccff_tail = 0, cfg_out = 0, frame_done = 0, busy = 0.
  - Reset mid-shift or mid-commit discards everything immediately.
- Shift (shift_en=1, capture=0):
  - Per chain, sr <= {sr[CHAIN_LEN-2:0], ccff_head[c]}.
  - ccff_tail[c] = sr[CHAIN_LEN-1] (registered; first head bit emerges at the tail after CHAIN_LEN shifts).
  - shift_cnt increments and saturates at 2^CNT_W-1.
  - Shifting past CHAIN_LEN is legal (daisy-chain pass-through); no error is raised.
- Capture (capture=1):
  - sr <= shadow for all chains; shift_cnt <= 0; state IDLE.
  - Capture overrides shift_en in the same cycle.
- Commit (commit=1):
  - If frame_done=1: shadow <= current sr (pre-shift value if shift_en is also high; the shift still happens); shift_cnt <= 0 unless shift_en=1, in which case shift_cnt <= 1; state IDLE (or SHIFTING if shift_en=1).
  - If frame_done=0: shadow unchanged, commit_err=1 for exactly one cycle, shift/count proceed normally.
  - commit and capture in the same cycle: commit is evaluated, capture is ignored.
- FSM:
  - IDLE: shift_cnt == 0. Goes to SHIFTING on shift_en.
  - SHIFTING: 0 < shift_cnt < CHAIN_LEN. Goes to FULL when shift_cnt reaches CHAIN_LEN.
  - FULL: frame_done=1. Stays here on further shifts. Returns to IDLE on a valid commit or on capture.
  - From SHIFTING, capture also returns to IDLE.
- cfg_out = isol_n ? shadow : 0, combinational. Shadow is not altered by isol_n.
- No output changes except on a prog_clk edge or reset, apart from the isol_n gating.

Test Plan:
- Reset then release, NUM_CHAINS=2, CHAIN_LEN=8 -> cfg_out=0, ccff_tail=00, shift_cnt=0, busy=0, frame_done=0.
- Shift 8 bits, chain0 head sequence 1,0,1,1,0,0,1,0 (first bit first), chain1 all 1; then commit -> cfg_out[7:0]=8'b10110010, cfg_out[15:8]=8'hFF, shift_cnt=0, commit_err=0; frame_done rises on the 8th shift.
- Commit after only 5 shifts -> commit_err pulses for 1 cycle, cfg_out unchanged, shift_cnt=5, busy=1.
- After a commit of 0xA5 to chain0: capture, then 8 shifts with head=0 -> ccff_tail[0] emits 1,0,1,0,0,1,0,1 (MSB first), cfg_out still 0xA5.
- Shift 20 bits with CHAIN_LEN=8 -> ccff_tail replays the input delayed by 8 cycles; shift_cnt=20; frame_done=1; no error. Commit with shift_en high in the same cycle -> shadow holds the pre-shift value, shift_cnt=1.
- isol_n=0 with shadow=0xFFFF -> cfg_out=0; raise isol_n -> cfg_out=0xFFFF. Assert prog_reset mid-shift -> all outputs 0 asynchronously.
